channel_cmd_arbiter: RTL and testbench
======================================

// Module: channel_cmd_arbiter
// PURPOSE
//  Per-channel scheduler directly downstream of each per-rank controller's scheduler handshake outputs; feeds grants back to each rank.
//  Chooses the channel R/W mode with write-queue watermarks and enforces read/write turnaround.
//  Enforces tCCD CAS spacing on the shared DQ bus and round-robins CMD/DQ grants across NUM_RANK ranks.
// PARAMETERS
//  NUM_RANK    2   ranks on the channel (>=2)
//  RCNT_W      $clog2(READCMDQUEUEDEPTH)   per-rank read count width
//  WCNT_W      $clog2(WRITECMDQUEUEDEPTH)  per-rank write count width
//  WR_HIGH_WM  12  summed write count >= this forces READ->WRITE
//  WR_LOW_WM   4   summed write count < this allows WRITE->READ
//  T_CCD_S     4   CAS-to-CAS spacing, short (different bank group)
//  T_CCD_L     6   CAS-to-CAS spacing, long (same bank group)
//  T_RTRS      2   extra CAS spacing when consecutive CAS are to different ranks
//  T_RTW       8   read-to-write turnaround cycles
//  T_WTR       10  write-to-read turnaround cycles
//  STARVE_LIM  256 cycles; used only with CH_SCHED_STARVATION_EN
// PORTS
//  clk              in   1                single clock
//  rst              in   1                synchronous, active-high reset
//  rankRdReady      in   NUM_RANK         rank has pending read
//  rankWrReady      in   NUM_RANK         rank has pending write
//  rankReadReqCnt   in   NUM_RANK*RCNT_W  per-rank read queue occupancy
//  rankWriteReqCnt  in   NUM_RANK*WCNT_W  per-rank write queue occupancy
//  rankRdWrAck      in   NUM_RANK         rank issued RD/WR CAS this cycle
//  rankCmdAck       in   NUM_RANK         rank issued any command this cycle
//  rankFsmWait      in   NUM_RANK         rank waiting on tRCD/tRP/tRFC
//  rankCcdShort     in   NUM_RANK         1: tCCD_S applies to this CAS, 0: tCCD_L
//  rankIdle         in   NUM_RANK         rank FSMs all idle
//  cmdGranted       out  NUM_RANK         one-hot (or 0) CMD-bus grant
//  dqGranted        out  NUM_RANK         one-hot (or 0) CMD+DQ grant; subset of cmdGranted
//  writeMode        out  1                channel mode broadcast to all ranks
//  transReady       out  1                1 = steady mode, not in turnaround
// BEHAVIOUR
//  Reset: cmdGranted=0, dqGranted=0, writeMode=0, transReady=0 for one cycle then 1; FSM=READ; RR pointer=0; CCD counter=0.
//  All outputs registered; grants update one cycle after the inputs that cause them.
//  Mode FSM: READ, RD2WR, WRITE, WR2RD.
//   READ->RD2WR: sumWr>=WR_HIGH_WM, or (no rankRdReady and any rankWrReady).
//   WRITE->WR2RD: (sumWr<WR_LOW_WM and any rankRdReady), or no rankWrReady with any rankRdReady.
//   RD2WR/WR2RD: load counter T_RTW-1 / T_WTR-1; reach WRITE/READ when counter hits 0.
//   writeMode flips on entry to turnaround (target mode); transReady=0 throughout turnaround.
//   Mode-change decision is taken only in a cycle with no rankRdWrAck.
//  Sums: sumWr uses WCNT_W+$clog2(NUM_RANK) bits, no overflow.
//  Eligibility: rank i is eligible when it is ready in the current mode and rankFsmWait[i]==0.
//   CMD grant: RR from pointer over eligible ranks; one rank max.
//   dqGranted[i] = cmdGranted[i] & transReady & CCD counter==0.
//   Grant held until granted rank asserts rankCmdAck/rankRdWrAck or loses eligibility.
//   On release, pointer advances to granted rank+1 (mod NUM_RANK).
//  CCD counter: on rankRdWrAck[i] load (rankCcdShort?T_CCD_S:T_CCD_L)-1, +T_RTRS if i != last CAS rank; decrement to 0.
//  Ack from a non-granted rank: ignored for grant state, still loads CCD counter; simulation assertion fires.
//  Simultaneous mode switch and ack: ack processed first; switch deferred one cycle.
//  No ranks eligible: all grants 0, pointer unchanged.
//  Reset mid-operation drops grants in the same edge.
// CONFIGURATION
//  CH_SCHED_STARVATION_EN defined:
//   Counter increments while in WRITE with any rankRdReady.
//   At STARVE_LIM, force WRITE->WR2RD regardless of watermarks; counter clears on leaving WRITE.
//  CH_SCHED_STARVATION_EN undefined: watermark rules only; counter not instantiated.
// STRUCTURE
//  MemoryController_Definitions gains:
//   typedef enum logic[1:0] chMode_t {CH_READ, CH_RD2WR, CH_WRITE, CH_WR2RD}
//   T_CCD_S/T_CCD_L/T_RTRS/T_RTW/T_WTR defaults
//  Sub-module: rank_rr_arbiter (NUM_RANK request vector + pointer -> one-hot grant).
// TESTING
//  1. Reset, rank0 rankRdReady=1 -> cmdGranted=01, dqGranted=01 by cycle 2; writeMode=0.
//  2. Rank0 rdwrAck with ccdShort=0 -> dqGranted=0 for 5 cycles, then reasserted; with ccdShort=1 -> 3 cycles.
//  3. Both ranks ready, alternating acks -> grants 01,10,01; gap after rank switch = T_CCD_x-1+T_RTRS.
//  4. sumWr driven 11->12 with reads pending -> RD2WR: writeMode=1, transReady=0 for 8 cycles, then WRITE; no dqGranted in window.
//  5. In WRITE, drop sumWr to 3 with reads ready -> WR2RD for 10 cycles then READ; rst asserted mid-turnaround -> READ, grants 0 next cycle.
//  6. With CH_SCHED_STARVATION_EN, sumWr=20 constant, reads ready -> forced WR2RD after 256 cycles; without the macro -> stays WRITE.

Source files
------------

// File: rtl/channel_cmd_arbiter_pkg.sv
// rtl/channel_cmd_arbiter_pkg.sv - shared types, default timings and CAS spacing helper for the channel scheduler
package channel_cmd_arbiter_pkg;

  localparam int READCMDQUEUEDEPTH  = 16;
  localparam int WRITECMDQUEUEDEPTH = 16;

  localparam int DEF_NUM_RANK   = 2;
  localparam int DEF_RCNT_W     = $clog2(READCMDQUEUEDEPTH);
  localparam int DEF_WCNT_W     = $clog2(WRITECMDQUEUEDEPTH);
  localparam int DEF_WR_HIGH_WM = 12;
  localparam int DEF_WR_LOW_WM  = 4;
  localparam int DEF_T_CCD_S    = 4;
  localparam int DEF_T_CCD_L    = 6;
  localparam int DEF_T_RTRS     = 2;
  localparam int DEF_T_RTW      = 8;
  localparam int DEF_T_WTR      = 10;
  localparam int DEF_STARVE_LIM = 256;

  typedef enum logic [1:0] {
    CH_READ  = 2'd0,
    CH_RD2WR = 2'd1,
    CH_WRITE = 2'd2,
    CH_WR2RD = 2'd3
  } chMode_t;

  // Cycles the DQ bus stays blocked after a CAS; a rank switch adds the rank-to-rank gap.
  function automatic int casSpacing(input logic isShort, input logic rankSwitch,
                                    input int tCcdS, input int tCcdL, input int tRtrs);
    return (isShort ? tCcdS : tCcdL) - 1 + (rankSwitch ? tRtrs : 0);
  endfunction

endpackage

// File: rtl/channel_cmd_arbiter_if.sv
// rtl/channel_cmd_arbiter_if.sv - rank-to-channel scheduler handshake bundle
interface channel_cmd_arbiter_if
  import channel_cmd_arbiter_pkg::*;
#(
  parameter int NUM_RANK = DEF_NUM_RANK,
  parameter int RCNT_W   = DEF_RCNT_W,
  parameter int WCNT_W   = DEF_WCNT_W
);

  logic [NUM_RANK-1:0]        rankRdReady;
  logic [NUM_RANK-1:0]        rankWrReady;
  logic [NUM_RANK*RCNT_W-1:0] rankReadReqCnt;
  logic [NUM_RANK*WCNT_W-1:0] rankWriteReqCnt;
  logic [NUM_RANK-1:0]        rankRdWrAck;
  logic [NUM_RANK-1:0]        rankCmdAck;
  logic [NUM_RANK-1:0]        rankFsmWait;
  logic [NUM_RANK-1:0]        rankCcdShort;
  logic [NUM_RANK-1:0]        rankIdle;
  logic [NUM_RANK-1:0]        cmdGranted;
  logic [NUM_RANK-1:0]        dqGranted;
  logic                       writeMode;
  logic                       transReady;

  modport master (
    output rankRdReady, rankWrReady, rankReadReqCnt, rankWriteReqCnt,
           rankRdWrAck, rankCmdAck, rankFsmWait, rankCcdShort, rankIdle,
    input  cmdGranted, dqGranted, writeMode, transReady
  );

  modport slave (
    input  rankRdReady, rankWrReady, rankReadReqCnt, rankWriteReqCnt,
           rankRdWrAck, rankCmdAck, rankFsmWait, rankCcdShort, rankIdle,
    output cmdGranted, dqGranted, writeMode, transReady
  );

endinterface

// File: rtl/channel_cmd_arbiter_rank_rr_arbiter.sv
// rtl/channel_cmd_arbiter_rank_rr_arbiter.sv - round-robin one-hot pick starting at a pointer
module rank_rr_arbiter
  import channel_cmd_arbiter_pkg::*;
#(
  parameter int NUM_RANK = DEF_NUM_RANK,
  localparam int PTR_W   = $clog2(NUM_RANK)
) (
  input  logic [NUM_RANK-1:0] req,
  input  logic [PTR_W-1:0]    ptr,
  output logic [NUM_RANK-1:0] grant
);

  logic found;

  // Search from the pointer upward, then wrap to the ranks below it.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_RANK; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < NUM_RANK; i++) begin
      if (!found && req[i] && (i < int'(ptr))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/channel_cmd_arbiter.sv
// rtl/channel_cmd_arbiter.sv - channel R/W mode, turnaround, tCCD and rank grant scheduler; CH_SCHED_STARVATION_EN adds a read-starvation override
module channel_cmd_arbiter
  import channel_cmd_arbiter_pkg::*;
#(
  parameter int NUM_RANK   = DEF_NUM_RANK,
  parameter int RCNT_W     = DEF_RCNT_W,
  parameter int WCNT_W     = DEF_WCNT_W,
  parameter int WR_HIGH_WM = DEF_WR_HIGH_WM,
  parameter int WR_LOW_WM  = DEF_WR_LOW_WM,
  parameter int T_CCD_S    = DEF_T_CCD_S,
  parameter int T_CCD_L    = DEF_T_CCD_L,
  parameter int T_RTRS     = DEF_T_RTRS,
  parameter int T_RTW      = DEF_T_RTW,
  parameter int T_WTR      = DEF_T_WTR,
  parameter int STARVE_LIM = DEF_STARVE_LIM
) (
  input logic                  clk,
  input logic                  rst,
  channel_cmd_arbiter_if.slave bus
);

  localparam int PTR_W  = $clog2(NUM_RANK);
  localparam int SUM_W  = WCNT_W + $clog2(NUM_RANK);
  localparam int CCD_MX = ((T_CCD_L > T_CCD_S) ? T_CCD_L : T_CCD_S) + T_RTRS;
  localparam int CCD_W  = $clog2(CCD_MX + 1);
  localparam int TURN_W = $clog2(((T_RTW > T_WTR) ? T_RTW : T_WTR) + 1);

  localparam logic [SUM_W-1:0] WR_HIGH = SUM_W'(WR_HIGH_WM);
  localparam logic [SUM_W-1:0] WR_LOW  = SUM_W'(WR_LOW_WM);

  chMode_t             modeQ, modeD;
  logic [TURN_W-1:0]   turnCntQ, turnCntD;
  logic [CCD_W-1:0]    ccdCntQ, ccdD;
  logic [PTR_W-1:0]    lastCasQ, lastCasD;
  logic [PTR_W-1:0]    rrPtrQ, ptrD;
  logic [PTR_W-1:0]    grantIdx, ackIdx;
  logic [NUM_RANK-1:0] cmdGrantQ, grantD;
  logic [NUM_RANK-1:0] dqGrantQ, dqGrantD;
  logic [NUM_RANK-1:0] eligible, arbGrant;
  logic                writeModeQ, writeModeD;
  logic                transReadyQ, transReadyD;
  logic                hasGrant, releaseGrant;
  logic                anyRd, anyWr, anyCas, starveHit;
  logic [SUM_W-1:0]    sumWr;
  logic                unusedInputs;

  assign anyRd  = |bus.rankRdReady;
  assign anyWr  = |bus.rankWrReady;
  assign anyCas = |bus.rankRdWrAck;

  assign unusedInputs = ^{bus.rankReadReqCnt[NUM_RANK*RCNT_W-1:0], bus.rankIdle};

  assign bus.cmdGranted = cmdGrantQ;
  assign bus.dqGranted  = dqGrantQ;
  assign bus.writeMode  = writeModeQ;
  assign bus.transReady = transReadyQ;

  // Total write occupancy across ranks, wide enough that it cannot wrap.
  always_comb begin
    sumWr = '0;
    for (int i = 0; i < NUM_RANK; i++) begin
      sumWr = sumWr + SUM_W'(bus.rankWriteReqCnt[i*WCNT_W +: WCNT_W]);
    end
  end

`ifdef CH_SCHED_STARVATION_EN
  localparam int STARVE_W = $clog2(STARVE_LIM + 1);
  logic [STARVE_W-1:0] starveCntQ;

  // Count how long WRITE mode keeps pending reads waiting; cleared when WRITE is left.
  always_ff @(posedge clk) begin
    if (rst || (modeQ != CH_WRITE) || (modeD != CH_WRITE)) begin
      starveCntQ <= '0;
    end else if (anyRd && !starveHit) begin
      starveCntQ <= starveCntQ + STARVE_W'(1);
    end
  end

  assign starveHit = (starveCntQ == STARVE_W'(STARVE_LIM));
`else
  assign starveHit = (STARVE_LIM < 0);
`endif

  // Mode next-state: switches are only decided in cycles with no CAS ack.
  always_comb begin
    modeD    = modeQ;
    turnCntD = turnCntQ;
    case (modeQ)
      CH_READ: begin
        if (!anyCas && ((sumWr >= WR_HIGH) || (!anyRd && anyWr))) begin
          modeD    = CH_RD2WR;
          turnCntD = TURN_W'(T_RTW - 1);
        end
      end
      CH_RD2WR: begin
        if (turnCntQ == '0) modeD = CH_WRITE;
        else                turnCntD = turnCntQ - TURN_W'(1);
      end
      CH_WRITE: begin
        if (!anyCas && (((sumWr < WR_LOW) && anyRd) || (!anyWr && anyRd) || starveHit)) begin
          modeD    = CH_WR2RD;
          turnCntD = TURN_W'(T_WTR - 1);
        end
      end
      CH_WR2RD: begin
        if (turnCntQ == '0) modeD = CH_READ;
        else                turnCntD = turnCntQ - TURN_W'(1);
      end
      default: modeD = CH_READ;
    endcase
    writeModeD  = (modeD == CH_RD2WR) || (modeD == CH_WRITE);
    transReadyD = (modeD == CH_READ) || (modeD == CH_WRITE);
  end

  // Mode state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      modeQ    <= CH_READ;
      turnCntQ <= '0;
    end else begin
      modeQ    <= modeD;
      turnCntQ <= turnCntD;
    end
  end

  // CAS spacing: any ack reloads the counter, otherwise it drains to zero.
  always_comb begin
    ackIdx = '0;
    for (int i = NUM_RANK - 1; i >= 0; i--) begin
      if (bus.rankRdWrAck[i]) ackIdx = PTR_W'(i);
    end
    lastCasD = lastCasQ;
    ccdD     = ccdCntQ;
    if (anyCas) begin
      ccdD     = CCD_W'(casSpacing(bus.rankCcdShort[ackIdx], ackIdx != lastCasQ,
                                   T_CCD_S, T_CCD_L, T_RTRS));
      lastCasD = ackIdx;
    end else if (ccdCntQ != '0) begin
      ccdD = ccdCntQ - CCD_W'(1);
    end
  end

  // Eligibility in the upcoming mode, and pointer advance when the held grant is released.
  always_comb begin
    eligible = (writeModeD ? bus.rankWrReady : bus.rankRdReady) & ~bus.rankFsmWait;
    grantIdx = '0;
    for (int i = 0; i < NUM_RANK; i++) begin
      if (cmdGrantQ[i]) grantIdx = PTR_W'(i);
    end
    hasGrant     = |cmdGrantQ;
    releaseGrant = hasGrant &&
                   ((|(cmdGrantQ & (bus.rankCmdAck | bus.rankRdWrAck))) || !(|(cmdGrantQ & eligible)));
    ptrD = rrPtrQ;
    if (releaseGrant) begin
      ptrD = (grantIdx == PTR_W'(NUM_RANK - 1)) ? '0 : grantIdx + PTR_W'(1);
    end
  end

  rank_rr_arbiter #(
    .NUM_RANK (NUM_RANK)
  ) u_rr (
    .req   (eligible),
    .ptr   (ptrD),
    .grant (arbGrant)
  );

  // Keep the current grant until released; DQ grant also needs steady mode and a drained tCCD.
  always_comb begin
    grantD   = (hasGrant && !releaseGrant) ? cmdGrantQ : arbGrant;
    dqGrantD = grantD & {NUM_RANK{transReadyD && (ccdD == '0)}};
  end

  // Grant, pointer, CAS history and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ccdCntQ     <= '0;
      lastCasQ    <= '0;
      rrPtrQ      <= '0;
      cmdGrantQ   <= '0;
      dqGrantQ    <= '0;
      writeModeQ  <= 1'b0;
      transReadyQ <= 1'b0;
    end else begin
      ccdCntQ     <= ccdD;
      lastCasQ    <= lastCasD;
      rrPtrQ      <= ptrD;
      cmdGrantQ   <= grantD;
      dqGrantQ    <= dqGrantD;
      writeModeQ  <= writeModeD;
      transReadyQ <= transReadyD;
    end
  end

`ifndef SYNTHESIS
  // A rank may only issue while it holds the command-bus grant.
  ackOnlyWhenGranted: assert property (@(posedge clk) disable iff (rst)
    ((bus.rankRdWrAck | bus.rankCmdAck) & ~cmdGrantQ) == '0);
`endif

endmodule

// File: tb/tb_channel_cmd_arbiter.sv
// tb/tb_channel_cmd_arbiter.sv - directed self-checking bench for channel_cmd_arbiter
module tb_channel_cmd_arbiter;
  import channel_cmd_arbiter_pkg::*;

  localparam int WW = DEF_WCNT_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checkCnt = 0;
  int   errCnt   = 0;
  int   gap, len, dqSeen, n;

  channel_cmd_arbiter_if busIf ();

  channel_cmd_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (busIf)
  );

  always #5 clk = ~clk;

  task automatic checkResult(input string tag, input int obs, input int exp);
    checkCnt++;
    if (obs != exp) begin
      errCnt++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic setWr(input int c0, input int c1);
    busIf.rankWriteReqCnt = {WW'(c1), WW'(c0)};
  endtask

  // Pulse a CAS ack from one rank, then count cycles until a DQ grant reappears.
  task automatic ackAndGap(input int rank, input logic shortCcd, output int g);
    busIf.rankRdWrAck       = '0;
    busIf.rankRdWrAck[rank] = 1'b1;
    busIf.rankCcdShort      = {2{shortCcd}};
    @(negedge clk);
    busIf.rankRdWrAck = '0;
    g = 0;
    while ((busIf.dqGranted == '0) && (g < 40)) begin
      g++;
      @(negedge clk);
    end
  endtask

  // Count turnaround cycles and any DQ grant seen inside the window.
  task automatic measureLow(output int l, output int seen);
    l    = 0;
    seen = 0;
    while (!busIf.transReady && (l < 40)) begin
      l++;
      if (busIf.dqGranted != '0) seen++;
      @(negedge clk);
    end
  endtask

  initial begin
    busIf.rankRdReady     = '0;
    busIf.rankWrReady     = '0;
    busIf.rankReadReqCnt  = '0;
    busIf.rankWriteReqCnt = '0;
    busIf.rankRdWrAck     = '0;
    busIf.rankCmdAck      = '0;
    busIf.rankFsmWait     = '0;
    busIf.rankCcdShort    = '0;
    busIf.rankIdle        = '1;

    repeat (2) @(negedge clk);
    checkResult("rst_cmdGranted", busIf.cmdGranted, 0);
    checkResult("rst_dqGranted", busIf.dqGranted, 0);
    checkResult("rst_writeMode", busIf.writeMode, 0);
    checkResult("rst_transReady", busIf.transReady, 0);

    // 1: single rank read request
    rst = 1'b0;
    busIf.rankRdReady = 2'b01;
    @(negedge clk);
    checkResult("t1_cmdGranted", busIf.cmdGranted, 1);
    checkResult("t1_dqGranted", busIf.dqGranted, 1);
    checkResult("t1_writeMode", busIf.writeMode, 0);
    checkResult("t1_transReady", busIf.transReady, 1);

    // 2: same-rank CAS spacing, long then short
    ackAndGap(0, 1'b0, gap);
    checkResult("t2_gapLong", gap, 5);
    checkResult("t2_cmdHeld", busIf.cmdGranted, 1);
    ackAndGap(0, 1'b1, gap);
    checkResult("t2_gapShort", gap, 3);

    // 3: two ranks alternating
    busIf.rankRdReady = 2'b11;
    @(negedge clk);
    checkResult("t3_holdRank0", busIf.cmdGranted, 1);
    ackAndGap(0, 1'b0, gap);
    checkResult("t3_grantRank1", busIf.cmdGranted, 2);
    checkResult("t3_gapSameRank", gap, 5);
    ackAndGap(1, 1'b0, gap);
    checkResult("t3_grantRank0", busIf.cmdGranted, 1);
    checkResult("t3_gapSwitchLong", gap, 7);
    ackAndGap(0, 1'b1, gap);
    checkResult("t3_grantRank1b", busIf.cmdGranted, 2);
    checkResult("t3_gapSwitchShort", gap, 5);

    // 4: high watermark forces READ->RD2WR->WRITE
    busIf.rankWrReady = 2'b11;
    setWr(6, 5);
    repeat (2) @(negedge clk);
    checkResult("t4_belowHighWm", busIf.writeMode, 0);
    checkResult("t4_steadyRead", busIf.transReady, 1);
    setWr(6, 6);
    @(negedge clk);
    checkResult("t4_writeModeFlip", busIf.writeMode, 1);
    measureLow(len, dqSeen);
    checkResult("t4_rtwLen", len, 8);
    checkResult("t4_noDqInRtw", dqSeen, 0);
    checkResult("t4_writeSteady", busIf.writeMode, 1);
    checkResult("t4_dqInWrite", busIf.dqGranted, 2);

    // 5: low watermark returns to READ; reset mid-turnaround
    setWr(2, 1);
    @(negedge clk);
    checkResult("t5_readModeFlip", busIf.writeMode, 0);
    measureLow(len, dqSeen);
    checkResult("t5_wtrLen", len, 10);
    checkResult("t5_noDqInWtr", dqSeen, 0);
    checkResult("t5_readSteady", busIf.transReady, 1);
    setWr(6, 6);
    @(negedge clk);
    measureLow(len, dqSeen);
    checkResult("t5_rtwAgain", len, 8);
    setWr(2, 1);
    repeat (4) @(negedge clk);
    checkResult("t5_midTurnaround", busIf.transReady, 0);
    rst = 1'b1;
    @(negedge clk);
    checkResult("t5_rstCmd", busIf.cmdGranted, 0);
    checkResult("t5_rstDq", busIf.dqGranted, 0);
    checkResult("t5_rstWriteMode", busIf.writeMode, 0);
    checkResult("t5_rstTransReady", busIf.transReady, 0);
    rst = 1'b0;
    @(negedge clk);
    checkResult("t5_postRstTrans", busIf.transReady, 1);
    checkResult("t5_postRstMode", busIf.writeMode, 0);
    checkResult("t5_postRstGrant", busIf.cmdGranted, 1);

    // No eligible rank: grant dropped; release moved the pointer past rank 0
    busIf.rankFsmWait = 2'b11;
    @(negedge clk);
    checkResult("ne_cmdGranted", busIf.cmdGranted, 0);
    checkResult("ne_dqGranted", busIf.dqGranted, 0);
    busIf.rankFsmWait = 2'b00;
    @(negedge clk);
    checkResult("ne_regrant", busIf.cmdGranted, 2);

    // 6: sustained high write load with reads waiting
    setWr(10, 10);
    @(negedge clk);
    checkResult("t6_enterRd2Wr", busIf.writeMode, 1);
    measureLow(len, dqSeen);
    checkResult("t6_rtwLen", len, 8);
    n = 0;
    while (busIf.writeMode && (n < 400)) begin
      n++;
      @(negedge clk);
    end
`ifdef CH_SCHED_STARVATION_EN
    checkResult("t6_starveCycles", n, DEF_STARVE_LIM + 1);
    checkResult("t6_forcedWr2Rd", busIf.transReady, 0);
`else
    checkResult("t6_starveCycles", n, 400);
    checkResult("t6_staysWrite", busIf.writeMode, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

endmodule
